// File: rtl/counter_scheduler_pkg.sv
// Shared types, defaults and helpers for the time-shared interval counter.
package counter_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int MAX_REQ     = 8;
  localparam int MAX_IW      = 3;

  // Index of the set bit in a one-hot vector; zero when no bit is set.
  function automatic logic [MAX_IW-1:0] onehot_to_index(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = MAX_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping.
module rr_arbiter
  import counter_scheduler_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IW-1:0]      winner_idx,
  output logic               valid
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] upper_pick;
  logic [NUM_REQ-1:0] lower_pick;
  logic [NUM_REQ-1:0] pick;

  // Requests at or above the pointer take precedence over the wrapped ones.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign masked[gi] = req[gi] & (ptr <= IW'(gi));
    end
  endgenerate

  assign upper_pick = masked & (-masked);
  assign lower_pick = req & (-req);
  assign pick       = (|masked) ? upper_pick : lower_pick;

  assign valid         = enable & (|req);
  assign winner_onehot = valid ? pick : '0;
  assign winner_idx    = IW'(onehot_to_index(MAX_REQ'(pick)));

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin owner of one shared up-counter; each grant runs 0..limit then pulses done.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] limit,
  input  logic                     hold,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         count,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [NUM_REQ-1:0] done_reg;
  logic [WIDTH-1:0]   count_reg;
  logic [WIDTH-1:0]   lim_reg;
  logic               busy_reg;
  logic [IW-1:0]      ptr_reg;

  logic [NUM_REQ-1:0] win_onehot;
  logic [IW-1:0]      win_idx;
  logic               win_valid;
  logic [IW-1:0]      ptr_next;
  logic [WIDTH-1:0]   win_limit;
  logic               owner_req;
  logic               at_limit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req           (req),
    .ptr           (ptr_reg),
    .enable        (state_reg == IDLE),
    .winner_onehot (win_onehot),
    .winner_idx    (win_idx),
    .valid         (win_valid)
  );

  assign ptr_next  = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
  assign win_limit = limit[win_idx*WIDTH +: WIDTH];
  assign owner_req = |(req & grant_reg);
  assign at_limit  = (count_reg == lim_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      done_reg  <= '0;
      count_reg <= '0;
      lim_reg   <= '0;
      busy_reg  <= 1'b0;
      ptr_reg   <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            grant_reg <= win_onehot;
            lim_reg   <= win_limit;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            ptr_reg   <= ptr_next;
            state_reg <= RUN;
          end
        end
        RUN: begin
          // Owner dropping its request aborts silently and outranks completion.
          if (!owner_req) begin
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (!hold) begin
            if (at_limit) begin
              done_reg  <= grant_reg;
              grant_reg <= '0;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              count_reg <= count_reg + WIDTH'(1);
            end
          end
        end
        default: begin
          grant_reg <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign grant = grant_reg;
  assign done  = done_reg;
  assign count = count_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: expected {grant,done,count,busy} computed by hand per cycle.
module tb_counter_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] limit;
  logic        hold;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  count;
  logic        busy;

  int vectors;
  int miscompares;
  logic [16:0] got;
  logic [16:0] exp;

  counter_scheduler #(
    .NUM_REQ (4),
    .WIDTH   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .limit (limit),
    .hold  (hold),
    .grant (grant),
    .done  (done),
    .count (count),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    hold  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0001;
    hold  = 1'b0;
    limit = '0;
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b0000, 8'd0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_state got %h exp %h", got, exp);
    end
    tick();
    got = {grant, done, count, busy};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_overrides_req got %h exp %h", got, exp);
    end
    reset = 1'b0;
    req   = '0;
    $display("xact reset: outputs cleared");
  endtask

  task automatic test_basic();
    do_reset();
    limit[7:0] = 8'd3;
    req = 4'b0001;
    tick();
    for (int c = 0; c <= 3; c++) begin
      got = {grant, done, count, busy};
      exp = {4'b0001, 4'b0000, 8'(c), 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL basic_run c=%0d got %h exp %h", c, got, exp);
      end
      tick();
    end
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b0001, 8'd3, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL basic_done got %h exp %h", got, exp);
    end
    req = 4'b0000;
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b0000, 8'd3, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL basic_done_clear got %h exp %h", got, exp);
    end
    $display("xact basic: requester 0 interval of 4 cycles");
  endtask

  task automatic test_round_robin();
    do_reset();
    limit = {8'd1, 8'd1, 8'd1, 8'd1};
    req   = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c <= 1; c++) begin
        tick();
        got = {grant, done, count, busy};
        exp = {4'(1 << r), 4'b0000, 8'(c), 1'b1};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL rr_grant r=%0d c=%0d got %h exp %h", r, c, got, exp);
        end
      end
      tick();
      got = {grant, done, count, busy};
      exp = {4'b0000, 4'(1 << r), 8'd1, 1'b0};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rr_done r=%0d got %h exp %h", r, got, exp);
      end
      req[r] = 1'b0;
      $display("xact round_robin: requester %0d done", r);
    end
  endtask

  task automatic test_hold();
    do_reset();
    limit[23:16] = 8'd5;
    req = 4'b0100;
    for (int c = 0; c <= 2; c++) begin
      tick();
      got = {grant, done, count, busy};
      exp = {4'b0100, 4'b0000, 8'(c), 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hold_pre c=%0d got %h exp %h", c, got, exp);
      end
    end
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = {grant, done, count, busy};
      exp = {4'b0100, 4'b0000, 8'd2, 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hold_paused k=%0d got %h exp %h", k, got, exp);
      end
    end
    hold = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      tick();
      got = {grant, done, count, busy};
      exp = {4'b0100, 4'b0000, 8'(c), 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hold_post c=%0d got %h exp %h", c, got, exp);
      end
    end
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b0100, 8'd5, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL hold_done got %h exp %h", got, exp);
    end
    req = 4'b0000;
    $display("xact hold: requester 2 done after 9 grant cycles");
  endtask

  task automatic test_abort();
    do_reset();
    limit[15:8]  = 8'd10;
    limit[31:24] = 8'd2;
    req = 4'b0010;
    tick();
    req = 4'b1010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      got = {grant, done, count, busy};
      exp = {4'b0010, 4'b0000, 8'(c), 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL abort_run c=%0d got %h exp %h", c, got, exp);
      end
    end
    req = 4'b1000;
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b0000, 8'd4, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL abort_release got %h exp %h", got, exp);
    end
    for (int c = 0; c <= 2; c++) begin
      tick();
      got = {grant, done, count, busy};
      exp = {4'b1000, 4'b0000, 8'(c), 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL abort_next c=%0d got %h exp %h", c, got, exp);
      end
    end
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b1000, 8'd2, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL abort_next_done got %h exp %h", got, exp);
    end
    req = 4'b0000;
    $display("xact abort: requester 1 aborted, requester 3 done");
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    limit[7:0] = 8'd20;
    req = 4'b0001;
    for (int c = 0; c <= 7; c++) tick();
    got = {grant, done, count, busy};
    exp = {4'b0001, 4'b0000, 8'd7, 1'b1};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL midrst_pre got %h exp %h", got, exp);
    end
    reset = 1'b1;
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b0000, 8'd0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL midrst_clear got %h exp %h", got, exp);
    end
    reset = 1'b0;
    req = 4'b0011;
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0001, 4'b0000, 8'd0, 1'b1};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL midrst_regrant got %h exp %h", got, exp);
    end
    req = 4'b0000;
    tick();
    $display("xact reset_mid_run: interval aborted, requester 0 regranted");
  endtask

  task automatic test_limit_bounds();
    do_reset();
    limit[7:0]  = 8'd0;
    limit[15:8] = 8'd255;
    req = 4'b0011;
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0001, 4'b0000, 8'd0, 1'b1};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL lim0_grant got %h exp %h", got, exp);
    end
    tick();
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b0001, 8'd0, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL lim0_done got %h exp %h", got, exp);
    end
    req = 4'b0010;
    tick();
    limit[15:8] = 8'd3;
    for (int c = 0; c <= 255; c++) begin
      got = {grant, done, count, busy};
      exp = {4'b0010, 4'b0000, 8'(c), 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL limmax_run c=%0d got %h exp %h", c, got, exp);
      end
      tick();
    end
    got = {grant, done, count, busy};
    exp = {4'b0000, 4'b0010, 8'd255, 1'b0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL limmax_done got %h exp %h", got, exp);
    end
    req = 4'b0000;
    $display("xact limit_bounds: requester 0 limit 0, requester 1 limit 255 done");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req         = '0;
    hold        = 1'b0;
    limit       = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_hold();
    test_abort();
    test_reset_mid_run();
    test_limit_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Time-shares one WIDTH-bit up-counter, the same style as the team's free-running 8-bit counter, among NUM_REQ requesters.
- Each requester asks for an interval of N+1 clock cycles. The block arbitrates round-robin, grants exclusive ownership, runs the counter from 0 to the latched limit, then pulses done to the owner.
- Sits between the event-timing clients and the shared counter datapath. Owns the counter state internally and exposes count for observation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, counter and limit width in bits.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; must be held until done or voluntarily dropped (abort).
- limit  in  NUM_REQ*WIDTH  per-requester terminal value; slice i = limit[i*WIDTH +: WIDTH]; sampled only at grant.
- hold  in  1  pauses counting while high; grant is kept.
- grant  out  NUM_REQ  one-hot owner of the counter, or all zeros.
- done  out  NUM_REQ  one-cycle pulse to the owner on interval completion.
- count  out  WIDTH  current counter value.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE, grant=0, done=0, count=0, busy=0, rr pointer=0, latched limit=0. Reset overrides every other input, including mid-RUN; no done is issued for the aborted interval.
- States: IDLE, RUN. All outputs are registered.
- IDLE, some req bit high: select the first set req at or after the pointer (wrapping). At the edge: grant<=onehot(w), lim_q<=limit slice w, count<=0, busy<=1, ptr<=(w+1) mod NUM_REQ, state<=RUN.
- IDLE, no req: hold everything; count keeps its last value.
- RUN, req[w]=0 (abort; highest priority in RUN): at the edge grant<=0, busy<=0, no done, state<=IDLE. Count freezes.
- RUN, hold=1, req[w]=1: count unchanged, stay in RUN.
- RUN, hold=0, count==lim_q: at the edge done<=grant, grant<=0, busy<=0, state<=IDLE. Count stays at lim_q.
- RUN, hold=0, otherwise: count<=count+1.
- Latency: req sampled at edge E0 gives grant from E0 for lim_q+1 cycles (no hold). done is high in the first IDLE cycle afterwards.
- limit==0: grant lasts 1 cycle, then done.
- done clears after one cycle unconditionally.
- In the done cycle the block is in IDLE and arbitrates again. A requester still holding req may be re-granted only if no other requester is pending, because the pointer has advanced past it. Clients drop req on done.
- Counter arithmetic is unsigned WIDTH-bit. count never exceeds lim_q, so no wrap occurs. limit=2^WIDTH-1 gives a 2^WIDTH-cycle interval.
- Changes on limit while in RUN are ignored.
- A req rising during RUN waits. No preemption.

Decomposition:
- Package counter_scheduler_pkg holds:
  - state enum {IDLE, RUN};
  - localparam defaults NUM_REQ_DEF=4, WIDTH_DEF=8;
  - the function onehot_to_index.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req, ptr, enable;
  - outputs: one-hot winner, winner index, valid;
  - purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset, then req[0]=1 with limit0=3 -> grant=0001 for 4 cycles, count 0,1,2,3, then done=0001 for 1 cycle, busy 1→0.
- req=1111, all limits=1, each requester drops req on its done -> grant order 0,1,2,3, each 2 cycles, 4 done pulses, no overlap.
- req[2]=1, limit2=5, hold=1 for 3 cycles at count=2 -> count stays 2 for 3 cycles, grant lasts 9 cycles total, then done[2].
- req[1] granted (limit=10), req[1] dropped at count=4 -> grant=0 next cycle, no done, count frozen at 4; pending req[3] granted in the following cycle with count=0.
- Reset asserted mid-RUN at count=7 -> next cycle grant=0, count=0, busy=0, no done; afterwards req=0011 grants requester 0 first.
- limit0=0 and limit1=255, req=0011 -> grant0 for 1 cycle, done0, then grant1 for 256 cycles, count reaches 255, done1.
